// File: rtl/memory_stage.sv
// memory_stage: MEM pipeline stage with a simple IDLE/WAIT data-memory handshake
// and the MEM/WB pipeline register.
// Optional feature macro: MISALIGN_CHECK_EN, which traps misaligned half/word
// accesses instead of performing them at the aligned-down address.
module memory_stage #(
  parameter int D_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               valid_m,
  input  logic               reg_write_m,
  input  logic [1:0]         result_src_m,
  input  logic               mem_read_m,
  input  logic               mem_write_m,
  input  logic [2:0]         funct3_m,
  input  logic [D_WIDTH-1:0] alu_result_m,
  input  logic [D_WIDTH-1:0] write_data_m,
  input  logic [D_WIDTH-1:0] pc_plus4_m,
  input  logic [4:0]         rd_m,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [D_WIDTH-1:0] dmem_addr,
  output logic [D_WIDTH-1:0] dmem_wdata,
  output logic [3:0]         dmem_be,
  input  logic               dmem_ack,
  input  logic [D_WIDTH-1:0] dmem_rdata,
  output logic               stall_m,
  output logic               valid_w,
  output logic               reg_write_w,
  output logic [1:0]         result_src_w,
  output logic [D_WIDTH-1:0] alu_result_w,
  output logic [D_WIDTH-1:0] read_data_w,
  output logic [D_WIDTH-1:0] pc_plus4_w,
  output logic [4:0]         rd_w,
  output logic               misalign_w
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t             state, state_next;
  logic               mem_op;
  logic               misalign;
  logic               do_access;
  logic               complete;
  logic [1:0]         addr_lo;
  logic [7:0]         ld_byte;
  logic [15:0]        ld_half;
  logic [D_WIDTH-1:0] ld_data;

  assign addr_lo   = alu_result_m[1:0];
  assign mem_op    = valid_m & (mem_read_m | mem_write_m);
  assign do_access = mem_op & ~misalign;
  assign dmem_addr = {alu_result_m[D_WIDTH-1:2], 2'b00};
  assign dmem_we   = dmem_req & mem_write_m;

  // Misalignment detection: half accesses need addr[0]=0, word accesses addr[1:0]=0
  always_comb begin
    misalign = 1'b0;
`ifdef MISALIGN_CHECK_EN
    if (mem_op) begin
      if (funct3_m == 3'b001 || (mem_read_m && funct3_m == 3'b101))
        misalign = addr_lo[0];
      else if (funct3_m == 3'b010)
        misalign = (addr_lo != 2'b00);
    end
`endif
  end

  // Store lane steering: byte enables and replicated write data per access size
  always_comb begin
    dmem_be    = 4'b0000;
    dmem_wdata = write_data_m;
    if (mem_write_m) begin
      case (funct3_m)
        3'b000: begin
          dmem_be    = 4'b0001 << addr_lo;
          dmem_wdata = {4{write_data_m[7:0]}};
        end
        3'b001: begin
          dmem_be    = 4'b0011 << {addr_lo[1], 1'b0};
          dmem_wdata = {2{write_data_m[15:0]}};
        end
        default: dmem_be = 4'b1111;
      endcase
    end
  end

  // Load lane extraction with sign or zero extension
  always_comb begin
    ld_byte = dmem_rdata[7:0];
    case (addr_lo)
      2'd1:    ld_byte = dmem_rdata[15:8];
      2'd2:    ld_byte = dmem_rdata[23:16];
      2'd3:    ld_byte = dmem_rdata[31:24];
      default: ld_byte = dmem_rdata[7:0];
    endcase
    ld_half = addr_lo[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (funct3_m)
      3'b000:  ld_data = {{(D_WIDTH-8){ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {{(D_WIDTH-8){1'b0}}, ld_byte};
      3'b001:  ld_data = {{(D_WIDTH-16){ld_half[15]}}, ld_half};
      3'b101:  ld_data = {{(D_WIDTH-16){1'b0}}, ld_half};
      default: ld_data = dmem_rdata;
    endcase
  end

  // Handshake FSM: request in IDLE, hold in WAIT until ack; reset kills everything
  always_comb begin
    state_next = state;
    dmem_req   = 1'b0;
    stall_m    = 1'b0;
    complete   = 1'b0;
    case (state)
      IDLE: begin
        if (do_access) begin
          dmem_req = 1'b1;
          if (dmem_ack) complete = 1'b1;
          else          state_next = WAIT;
        end else begin
          complete = 1'b1;
        end
      end
      WAIT: begin
        dmem_req = 1'b1;
        stall_m  = 1'b1;
        if (dmem_ack) begin
          complete   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (!rst_n) begin
      state_next = IDLE;
      dmem_req   = 1'b0;
      stall_m    = 1'b0;
      complete   = 1'b0;
    end
  end

  // State register and MEM/WB register: load on completion, otherwise insert a bubble
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      valid_w      <= 1'b0;
      reg_write_w  <= 1'b0;
      result_src_w <= 2'b00;
      alu_result_w <= '0;
      read_data_w  <= '0;
      pc_plus4_w   <= '0;
      rd_w         <= 5'd0;
      misalign_w   <= 1'b0;
    end else begin
      state <= state_next;
      if (complete && valid_m) begin
        valid_w      <= 1'b1;
        reg_write_w  <= reg_write_m & ~misalign;
        result_src_w <= result_src_m;
        alu_result_w <= alu_result_m;
        read_data_w  <= (mem_read_m && !misalign) ? ld_data : '0;
        pc_plus4_w   <= pc_plus4_m;
        rd_w         <= rd_m;
        misalign_w   <= misalign;
      end else begin
        valid_w     <= 1'b0;
        reg_write_w <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: directed self-checking bench for memory_stage.
// Inputs change on the falling edge; combinational outputs are sampled there,
// registered outputs are sampled 1 time unit after the rising edge.
module tb_memory_stage;

  logic        clk;
  logic        rst_n;
  logic        valid_m, reg_write_m, mem_read_m, mem_write_m;
  logic [1:0]  result_src_m;
  logic [2:0]  funct3_m;
  logic [31:0] alu_result_m, write_data_m, pc_plus4_m;
  logic [4:0]  rd_m;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        stall_m, valid_w, reg_write_w, misalign_w;
  logic [1:0]  result_src_w;
  logic [31:0] alu_result_w, read_data_w, pc_plus4_w;
  logic [4:0]  rd_w;

  int checks = 0;
  int errors = 0;

  memory_stage #(.D_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .valid_m(valid_m), .reg_write_m(reg_write_m), .result_src_m(result_src_m),
    .mem_read_m(mem_read_m), .mem_write_m(mem_write_m), .funct3_m(funct3_m),
    .alu_result_m(alu_result_m), .write_data_m(write_data_m),
    .pc_plus4_m(pc_plus4_m), .rd_m(rd_m),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .stall_m(stall_m), .valid_w(valid_w), .reg_write_w(reg_write_w),
    .result_src_w(result_src_w), .alu_result_w(alu_result_w),
    .read_data_w(read_data_w), .pc_plus4_w(pc_plus4_w), .rd_w(rd_w),
    .misalign_w(misalign_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_op(input logic v, input logic rw, input logic [1:0] rs,
                          input logic mr, input logic mw, input logic [2:0] f3,
                          input logic [31:0] alu, input logic [31:0] wd,
                          input logic [31:0] pc, input logic [4:0] rd);
    valid_m = v; reg_write_m = rw; result_src_m = rs; mem_read_m = mr;
    mem_write_m = mw; funct3_m = f3; alu_result_m = alu; write_data_m = wd;
    pc_plus4_m = pc; rd_m = rd;
  endtask

  task automatic drive_idle();
    drive_op(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 5'd0);
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive_op(1'b1, 1'b1, 2'b01, 1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 32'h8, 5'd3);
    #1;
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req: got %b expected 0", dmem_req); end
    checks++; if (stall_m !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall: got %b expected 0", stall_m); end
    @(posedge clk); #1;
    checks++; if (valid_w !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid_w: got %b expected 0", valid_w); end
    checks++; if ({alu_result_w, read_data_w, pc_plus4_w, rd_w, misalign_w, reg_write_w} !== '0) begin errors++; $display("[TB] FAIL reset_fields: alu %h rd %h pc %h", alu_result_w, read_data_w, pc_plus4_w); end
    @(negedge clk);
    rst_n = 1'b1;
    drive_idle();
    @(posedge clk); #1;
  endtask

  task automatic test_alu();
    @(negedge clk);
    drive_op(1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 3'b000, 32'h1234, 32'h0, 32'h44, 5'd5);
    #1;
    checks++; if (stall_m !== 1'b0) begin errors++; $display("[TB] FAIL alu_stall: got %b expected 0", stall_m); end
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("[TB] FAIL alu_req: got %b expected 0", dmem_req); end
    @(posedge clk); #1;
    checks++; if (valid_w !== 1'b1 || reg_write_w !== 1'b1) begin errors++; $display("[TB] FAIL alu_valid: got %b%b expected 11", valid_w, reg_write_w); end
    checks++; if (alu_result_w !== 32'h1234) begin errors++; $display("[TB] FAIL alu_result: got %h expected 00001234", alu_result_w); end
    checks++; if (rd_w !== 5'd5 || pc_plus4_w !== 32'h44 || read_data_w !== 32'h0) begin errors++; $display("[TB] FAIL alu_pass: rd %0d pc %h rdata %h expected 5 44 0", rd_w, pc_plus4_w, read_data_w); end
    checks++; if (stall_m !== 1'b0) begin errors++; $display("[TB] FAIL alu_stall_after: got %b expected 0", stall_m); end
  endtask

  task automatic test_load_wait();
    int stalls = 0;
    @(negedge clk);
    drive_op(1'b1, 1'b1, 2'b01, 1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h20, 5'd7);
    dmem_rdata = 32'h80FF_FF12; dmem_ack = 1'b0;
    #1;
    checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== 32'h100 || dmem_be !== 4'b0000) begin errors++; $display("[TB] FAIL lb_req: req %b we %b addr %h be %b expected 1 0 100 0000", dmem_req, dmem_we, dmem_addr, dmem_be); end
    checks++; if (stall_m !== 1'b0) begin errors++; $display("[TB] FAIL lb_stall_first: got %b expected 0", stall_m); end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++; if (valid_w !== 1'b0 || reg_write_w !== 1'b0) begin errors++; $display("[TB] FAIL lb_bubble%0d: got %b%b expected 00", i, valid_w, reg_write_w); end
      @(negedge clk);
      if (i == 1) dmem_ack = 1'b1;
      #1;
      if (stall_m === 1'b1) stalls++;
      checks++; if (dmem_req !== 1'b1 || dmem_addr !== 32'h100) begin errors++; $display("[TB] FAIL lb_hold%0d: req %b addr %h expected 1 100", i, dmem_req, dmem_addr); end
    end
    checks++; if (stalls != 2) begin errors++; $display("[TB] FAIL lb_stall_count: got %0d expected 2", stalls); end
    @(posedge clk); #1;
    checks++; if (valid_w !== 1'b1 || read_data_w !== 32'hFFFF_FF80) begin errors++; $display("[TB] FAIL lb_data: valid %b data %h expected 1 ffffff80", valid_w, read_data_w); end
    checks++; if (stall_m !== 1'b0) begin errors++; $display("[TB] FAIL lb_stall_end: got %b expected 0", stall_m); end
    @(negedge clk);
    drive_idle();
  endtask

  task automatic test_stores();
    logic [31:0] addr_t [3];
    logic [31:0] wd_t   [3];
    logic [2:0]  f3_t   [3];
    logic [3:0]  be_t   [3];
    logic [31:0] exp_t  [3];
    addr_t = '{32'h102, 32'h101, 32'h200};
    wd_t   = '{32'h0000_ABCD, 32'h0000_005A, 32'hDEAD_BEEF};
    f3_t   = '{3'b001, 3'b000, 3'b010};
    be_t   = '{4'b1100, 4'b0010, 4'b1111};
    exp_t  = '{32'hABCD_ABCD, 32'h5A5A_5A5A, 32'hDEAD_BEEF};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive_op(1'b1, 1'b0, 2'b00, 1'b0, 1'b1, f3_t[i], addr_t[i], wd_t[i], 32'h30, 5'd0);
      dmem_ack = 1'b1;
      #1;
      checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || stall_m !== 1'b0) begin errors++; $display("[TB] FAIL st%0d_req: req %b we %b stall %b expected 1 1 0", i, dmem_req, dmem_we, stall_m); end
      checks++; if (dmem_be !== be_t[i] || dmem_wdata !== exp_t[i] || dmem_addr !== {addr_t[i][31:2], 2'b00}) begin errors++; $display("[TB] FAIL st%0d_lanes: be %b wdata %h addr %h expected %b %h", i, dmem_be, dmem_wdata, dmem_addr, be_t[i], exp_t[i]); end
      @(posedge clk); #1;
      checks++; if (valid_w !== 1'b1 || reg_write_w !== 1'b0 || read_data_w !== 32'h0) begin errors++; $display("[TB] FAIL st%0d_done: valid %b rw %b rdata %h expected 1 0 0", i, valid_w, reg_write_w, read_data_w); end
    end
    @(negedge clk);
    drive_idle();
  endtask

  task automatic test_loads_zero_wait();
    logic [31:0] addr_t [3];
    logic [31:0] rd_t   [3];
    logic [2:0]  f3_t   [3];
    logic [31:0] exp_t  [3];
    addr_t = '{32'h102, 32'h100, 32'h101};
    rd_t   = '{32'hBEEF_0000, 32'h0000_8001, 32'h0000_F300};
    f3_t   = '{3'b101, 3'b001, 3'b100};
    exp_t  = '{32'h0000_BEEF, 32'hFFFF_8001, 32'h0000_00F3};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive_op(1'b1, 1'b1, 2'b01, 1'b1, 1'b0, f3_t[i], addr_t[i], 32'h0, 32'h50, 5'd9);
      dmem_rdata = rd_t[i]; dmem_ack = 1'b1;
      #1;
      checks++; if (dmem_be !== 4'b0000 || stall_m !== 1'b0) begin errors++; $display("[TB] FAIL ld%0d_be: be %b stall %b expected 0000 0", i, dmem_be, stall_m); end
      @(posedge clk); #1;
      checks++; if (valid_w !== 1'b1 || read_data_w !== exp_t[i]) begin errors++; $display("[TB] FAIL ld%0d_data: valid %b data %h expected 1 %h", i, valid_w, read_data_w, exp_t[i]); end
    end
    @(negedge clk);
    drive_idle();
  endtask

  task automatic test_reset_in_wait();
    @(negedge clk);
    drive_op(1'b1, 1'b1, 2'b01, 1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 32'h60, 5'd11);
    dmem_ack = 1'b0; dmem_rdata = 32'h1111_2222;
    @(posedge clk); #1;
    checks++; if (stall_m !== 1'b1) begin errors++; $display("[TB] FAIL rw_enter_wait: stall %b expected 1", stall_m); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (dmem_req !== 1'b0 || stall_m !== 1'b0) begin errors++; $display("[TB] FAIL rw_force: req %b stall %b expected 0 0", dmem_req, stall_m); end
    @(posedge clk); #1;
    checks++; if ({valid_w, reg_write_w, result_src_w, alu_result_w, read_data_w, pc_plus4_w, rd_w, misalign_w} !== '0) begin errors++; $display("[TB] FAIL rw_clear: valid %b alu %h rdata %h pc %h rd %0d expected all 0", valid_w, alu_result_w, read_data_w, pc_plus4_w, rd_w); end
    @(negedge clk);
    rst_n = 1'b1;
    drive_idle();
    dmem_ack = 1'b1; dmem_rdata = 32'h1111_2222;
    #1;
    checks++; if (dmem_req !== 1'b0 || stall_m !== 1'b0) begin errors++; $display("[TB] FAIL rw_late_ack_req: req %b stall %b expected 0 0", dmem_req, stall_m); end
    @(posedge clk); #1;
    checks++; if (valid_w !== 1'b0 || read_data_w !== 32'h0) begin errors++; $display("[TB] FAIL rw_late_ack_wb: valid %b rdata %h expected 0 0", valid_w, read_data_w); end
    @(negedge clk);
    dmem_ack = 1'b0;
  endtask

  task automatic test_misalign();
    @(negedge clk);
    drive_op(1'b1, 1'b1, 2'b01, 1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 32'h70, 5'd12);
    dmem_rdata = 32'h1122_3344; dmem_ack = 1'b1;
    #1;
`ifdef MISALIGN_CHECK_EN
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("[TB] FAIL mis_req: got %b expected 0", dmem_req); end
    @(posedge clk); #1;
    checks++; if (valid_w !== 1'b1 || misalign_w !== 1'b1 || reg_write_w !== 1'b0) begin errors++; $display("[TB] FAIL mis_wb: valid %b mis %b rw %b expected 1 1 0", valid_w, misalign_w, reg_write_w); end
`else
    checks++; if (dmem_req !== 1'b1 || dmem_addr !== 32'h100) begin errors++; $display("[TB] FAIL mis_req: req %b addr %h expected 1 100", dmem_req, dmem_addr); end
    @(posedge clk); #1;
    checks++; if (valid_w !== 1'b1 || misalign_w !== 1'b0 || reg_write_w !== 1'b1 || read_data_w !== 32'h1122_3344) begin errors++; $display("[TB] FAIL mis_wb: valid %b mis %b rw %b data %h expected 1 0 1 11223344", valid_w, misalign_w, reg_write_w, read_data_w); end
`endif
    @(negedge clk);
    drive_idle();
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    drive_op(1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 3'b000, 32'hA, 32'h0, 32'h80, 5'd1);
    @(posedge clk); #1;
    checks++; if (valid_w !== 1'b1 || alu_result_w !== 32'hA) begin errors++; $display("[TB] FAIL b2b_first: valid %b alu %h expected 1 a", valid_w, alu_result_w); end
    @(negedge clk);
    drive_op(1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 3'b000, 32'hB, 32'h0, 32'h84, 5'd2);
    @(posedge clk); #1;
    checks++; if (valid_w !== 1'b1 || alu_result_w !== 32'hB || result_src_w !== 2'b10 || rd_w !== 5'd2) begin errors++; $display("[TB] FAIL b2b_second: valid %b alu %h src %b rd %0d expected 1 b 10 2", valid_w, alu_result_w, result_src_w, rd_w); end
    @(negedge clk);
    drive_idle();
    @(posedge clk); #1;
    checks++; if (valid_w !== 1'b0 || reg_write_w !== 1'b0 || alu_result_w !== 32'hB || rd_w !== 5'd2) begin errors++; $display("[TB] FAIL b2b_bubble: valid %b rw %b alu %h rd %0d expected 0 0 b 2", valid_w, reg_write_w, alu_result_w, rd_w); end
  endtask

  initial begin
    rst_n = 1'b0;
    drive_idle();
    test_reset();
    test_alu();
    test_load_wait();
    test_stores();
    test_loads_zero_wait();
    test_reset_in_wait();
    test_misalign();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
